// File: rtl/fp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp_pkg                                                     |
// | Brief   : Shared single-precision field widths, constants, FSM type  |
// |           and operand classification helpers for fp_accumulator.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;
  // Largest finite biased exponent.
  localparam int EXP_MAX = 2 * BIAS;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Zero exponent covers true zeros and denormals, both treated as zero.
  function automatic logic is_zero(input logic [31:0] v);
    return v[MAN_W +: EXP_W] == '0;
  endfunction

  function automatic logic is_inf(input logic [31:0] v);
    return (v[MAN_W +: EXP_W] == '1) && (v[MAN_W-1:0] == '0);
  endfunction

  function automatic logic is_nan(input logic [31:0] v);
    return (v[MAN_W +: EXP_W] == '1) && (v[MAN_W-1:0] != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_lzc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp_lzc                                                     |
// | Brief   : Combinational 24-bit leading-zero counter (0..24).         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fp_lzc (
  input  logic [23:0] din,
  output logic [4:0]  cnt
);

  // Scan upward so the highest set bit is the last to write the count.
  always_comb begin
    cnt = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) cnt = 5'(23 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : fp_accumulator                                             |
// | Brief   : Multi-cycle IEEE-754 single-precision running adder.       |
// |           IDLE->ALIGN->ADD->NORM->DONE, truncating, denormals flushed.|
// |           Optional macro FP_ACC_TERM_COUNT_EN adds term_cnt output.  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_ovf,
  input  logic        clear,
  output logic        in_ready,
  output logic [31:0] acc_out,
  output logic        acc_valid,
  output logic        overflow,
  output logic        nan_flag
`ifdef FP_ACC_TERM_COUNT_EN
  ,
  output logic [CNT_W-1:0] term_cnt
`endif
);

  state_t      r_state;
  logic [31:0] r_acc, r_b, r_spec_val, r_res;
  logic        r_valid, r_ovf, r_nan, r_ready, r_term_ovf;
  logic        r_sign, r_sub, r_spec, r_spec_nan, r_res_nan, r_res_ovf;
  logic [EXP_W-1:0] r_exp;
  logic [24:0] r_ml, r_ms;
  logic [25:0] r_sum;

  logic        w_swap, w_spec, w_spec_nan, w_res_nan, w_res_ovf;
  logic [31:0] w_big, w_small, w_spec_val, w_res;
  logic [23:0] w_big_man, w_small_man, w_lsh;
  logic [EXP_W-1:0] w_diff;
  logic [24:0] w_small_sh;
  logic [25:0] w_sum;
  logic [4:0]  w_lz;
  logic signed [9:0] w_exp_n;
  logic [22:0] w_frac;
  logic        w_unused;

  // Alignment: order operands by magnitude, shift the smaller one, detect specials.
  always_comb begin
    w_swap      = (is_zero(r_b) ? 31'd0 : r_b[30:0]) > (is_zero(r_acc) ? 31'd0 : r_acc[30:0]);
    w_big       = w_swap ? r_b : r_acc;
    w_small     = w_swap ? r_acc : r_b;
    w_big_man   = is_zero(w_big)   ? 24'd0 : {1'b1, w_big[MAN_W-1:0]};
    w_small_man = is_zero(w_small) ? 24'd0 : {1'b1, w_small[MAN_W-1:0]};
    w_diff      = w_big[MAN_W +: EXP_W] - w_small[MAN_W +: EXP_W];
    w_small_sh  = (w_diff >= EXP_W'(26)) ? 25'd0 : ({w_small_man, 1'b0} >> w_diff);
    w_spec      = 1'b1;
    w_spec_nan  = 1'b0;
    w_spec_val  = QNAN;
    if (is_nan(r_acc) || is_nan(r_b) ||
        (is_inf(r_acc) && is_inf(r_b) && (r_acc[31] != r_b[31]))) begin
      w_spec_nan = 1'b1;
    end else if (is_inf(r_acc)) begin
      w_spec_val = r_acc;
    end else if (is_inf(r_b)) begin
      w_spec_val = r_b;
    end else begin
      w_spec = 1'b0;
    end
  end

  // Magnitude add/subtract; the larger operand is always the minuend.
  assign w_sum = r_sub ? ({1'b0, r_ml} - {1'b0, r_ms}) : ({1'b0, r_ml} + {1'b0, r_ms});

  fp_lzc u_lzc (
    .din (r_sum[24:1]),
    .cnt (w_lz)
  );

  // Left shift keeps the guard bit so it can become a fraction bit.
  assign w_lsh    = r_sum[23:0] << w_lz;
  assign w_frac   = r_sum[25] ? r_sum[24:2] : w_lsh[23:1];
  assign w_exp_n  = r_sum[25] ? ($signed({2'b00, r_exp}) + 10'sd1)
                              : ($signed({2'b00, r_exp}) - $signed({5'd0, w_lz}));
  assign w_unused = w_lsh[0];

  // Normalisation: pick special result, flush underflow/cancellation, saturate to infinity.
  always_comb begin
    w_res_ovf = 1'b0;
    w_res_nan = 1'b0;
    if (r_spec) begin
      w_res     = r_spec_val;
      w_res_nan = r_spec_nan;
    end else if ((r_sum == 26'd0) || (w_exp_n <= 10'sd0)) begin
      w_res = 32'h00000000;
    end else if (w_exp_n > $signed(10'(EXP_MAX))) begin
      w_res     = {r_sign, POS_INF[30:0]};
      w_res_ovf = 1'b1;
    end else begin
      w_res = {r_sign, w_exp_n[EXP_W-1:0], w_frac};
    end
  end

`ifdef FP_ACC_TERM_COUNT_EN
  logic [CNT_W-1:0] r_term_cnt;
  assign term_cnt = r_term_cnt;
`else
  // Keeps the counter width parameter referenced when the counter is compiled out.
  logic [CNT_W-1:0] w_cnt_unused;
  assign w_cnt_unused = '0;
`endif

  // Control FSM and datapath pipeline; reset and clear abort any in-flight term.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      r_state <= IDLE;
      r_acc   <= 32'h00000000;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_nan   <= 1'b0;
      // Ready stays low while reset is held, but a clear leaves the block ready.
      r_ready <= rst;
`ifdef FP_ACC_TERM_COUNT_EN
      r_term_cnt <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (in_valid && r_ready) begin
            r_b        <= in_data;
            r_term_ovf <= in_ovf;
            r_ready    <= 1'b0;
            r_state    <= ALIGN;
`ifdef FP_ACC_TERM_COUNT_EN
            if (r_term_cnt != '1) r_term_cnt <= r_term_cnt + CNT_W'(1);
`endif
          end else begin
            r_ready <= 1'b1;
          end
        end
        ALIGN: begin
          r_sign     <= w_big[31];
          r_exp      <= w_big[MAN_W +: EXP_W];
          r_ml       <= {w_big_man, 1'b0};
          r_ms       <= w_small_sh;
          r_sub      <= w_big[31] ^ w_small[31];
          r_spec     <= w_spec;
          r_spec_nan <= w_spec_nan;
          r_spec_val <= w_spec_val;
          r_state    <= ADD;
        end
        ADD: begin
          r_sum   <= w_sum;
          r_state <= NORM;
        end
        NORM: begin
          r_res     <= w_res;
          r_res_nan <= w_res_nan;
          r_res_ovf <= w_res_ovf;
          r_state   <= DONE;
        end
        DONE: begin
          r_acc   <= r_res;
          r_valid <= 1'b1;
          r_ovf   <= r_ovf | r_res_ovf | r_term_ovf;
          r_nan   <= r_nan | r_res_nan;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign acc_out   = r_acc;
  assign acc_valid = r_valid;
  assign overflow  = r_ovf;
  assign nan_flag  = r_nan;

endmodule
`default_nettype wire

// File: tb/tb_fp_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_fp_accumulator                                          |
// | Brief   : Directed self-checking bench for fp_accumulator.           |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ovf = 1'b0;
  logic        clear = 1'b0;
  logic        in_ready, acc_valid, overflow, nan_flag;
  logic [31:0] acc_out;

  int checks = 0;
  int errors = 0;

  fp_accumulator #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ovf    (in_ovf),
    .clear     (clear),
    .in_ready  (in_ready),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .overflow  (overflow),
    .nan_flag  (nan_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Offer one term, then wait for the result pulse and check its latency.
  task automatic accept(input logic [31:0] d, input logic ovf, input string tag);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check({tag, " ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_ovf   = ovf;
    step();
    in_valid = 1'b0;
    in_ovf   = 1'b0;
    check({tag, " busy"}, {31'd0, in_ready}, 32'd0);
    lat = -1;
    for (int k = 0; k <= 8; k++) begin
      if (acc_valid) begin
        lat = k;
        break;
      end
      step();
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
  endtask

  initial begin
    int pulses;

    // Reset held
    rst = 1'b0;
    step();
    step();
    check("rst acc_out", acc_out, 32'h0);
    check("rst acc_valid", {31'd0, acc_valid}, 32'd0);
    check("rst overflow", {31'd0, overflow}, 32'd0);
    check("rst nan_flag", {31'd0, nan_flag}, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // 1 + 2 = 3
    accept(32'h3F800000, 1'b0, "t1a");
    check("t1a acc", acc_out, 32'h3F800000);
    accept(32'h40000000, 1'b0, "t1b");
    check("t1b acc", acc_out, 32'h40400000);
    check("t1b overflow", {31'd0, overflow}, 32'd0);
    step();
    check("t1 pulse width", {31'd0, acc_valid}, 32'd0);

    // 10 + -20 = -10
    do_clear();
    accept(32'h41200000, 1'b0, "t2a");
    accept(32'hC1A00000, 1'b0, "t2b");
    check("t2 acc", acc_out, 32'hC1200000);

    // Exact cancellation gives +0
    do_clear();
    accept(32'h3F800000, 1'b0, "t3a");
    accept(32'hBF800000, 1'b0, "t3b");
    check("t3 acc", acc_out, 32'h00000000);
    check("t3 nan", {31'd0, nan_flag}, 32'd0);

    // Shift of 30 places discards the small term entirely
    do_clear();
    accept(32'h3F800000, 1'b0, "t4a");
    accept(32'h30800000, 1'b0, "t4b");
    check("t4 acc", acc_out, 32'h3F800000);

    // Max finite twice overflows to +inf; overflow is sticky
    do_clear();
    accept(32'h7F7FFFFF, 1'b0, "t5a");
    accept(32'h7F7FFFFF, 1'b0, "t5b");
    check("t5 acc", acc_out, 32'h7F800000);
    check("t5 overflow", {31'd0, overflow}, 32'd1);
    accept(32'h3F800000, 1'b0, "t5c");
    check("t5c acc", acc_out, 32'h7F800000);
    check("t5c overflow", {31'd0, overflow}, 32'd1);

    // +inf + -inf = qNaN, then clear
    do_clear();
    check("t6 clr overflow", {31'd0, overflow}, 32'd0);
    accept(32'h7F800000, 1'b0, "t6a");
    check("t6a acc", acc_out, 32'h7F800000);
    accept(32'hFF800000, 1'b0, "t6b");
    check("t6 acc", acc_out, 32'h7FC00000);
    check("t6 nan", {31'd0, nan_flag}, 32'd1);
    do_clear();
    check("t6 clr acc", acc_out, 32'h0);
    check("t6 clr nan", {31'd0, nan_flag}, 32'd0);

    // Clear during ALIGN discards the term
    accept(32'h3F800000, 1'b0, "t7a");
    step();
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    step();
    in_valid = 1'b0;
    clear    = 1'b1;
    step();
    clear    = 1'b0;
    check("t7 acc", acc_out, 32'h0);
    check("t7 ready", {31'd0, in_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (acc_valid) pulses++;
      step();
    end
    check("t7 pulses", 32'(pulses), 32'd0);

    // Clear and in_valid together: term refused
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    clear    = 1'b1;
    step();
    in_valid = 1'b0;
    clear    = 1'b0;
    check("t8 ready", {31'd0, in_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (acc_valid) pulses++;
      step();
    end
    check("t8 pulses", 32'(pulses), 32'd0);
    check("t8 acc", acc_out, 32'h0);

    // Upstream overflow flag on an accepted term
    accept(32'h40000000, 1'b1, "t9");
    check("t9 acc", acc_out, 32'h40000000);
    check("t9 overflow", {31'd0, overflow}, 32'd1);

    // Reset mid-operation
    step();
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    step();
    in_valid = 1'b0;
    rst      = 1'b0;
    step();
    check("t10 acc", acc_out, 32'h0);
    check("t10 overflow", {31'd0, overflow}, 32'd0);
    check("t10 ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    check("t10 post ready", {31'd0, in_ready}, 32'd1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (acc_valid) pulses++;
      step();
    end
    check("t10 pulses", 32'(pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fp_accumulator.md
FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 Parameter CNT_W, default 8, width of the accepted-term counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-low (asserted when 0).
REQ-004 in_valid  input  1  upstream multiplier product present (driven from multiplier done).
REQ-005 in_data  input  32  IEEE-754 single-precision product.
REQ-006 in_ovf  input  1  upstream overflow flag accompanying in_data.
REQ-007 clear  input  1  zero the accumulator and flags.
REQ-008 in_ready  output  1  high only in IDLE; a term is accepted when in_valid && in_ready.
REQ-009 acc_out  output  32  running IEEE-754 sum.
REQ-010 acc_valid  output  1  one-cycle pulse when acc_out is updated.
REQ-011 overflow  output  1  sticky: sum overflowed or an accepted term carried in_ovf.
REQ-012 nan_flag  output  1  sticky: sum is NaN.

Function
REQ-013 FSM states IDLE, ALIGN, ADD, NORM, DONE; acceptance in IDLE moves to ALIGN, then one cycle each, DONE returns to IDLE.
REQ-014 Latency: acc_valid pulses exactly 4 cycles after the acceptance edge; throughput one term per 5 cycles.
REQ-015 ALIGN: larger-exponent operand kept; smaller mantissa (hidden bit restored) right-shifted by the exponent difference, plus guard bit; shift >= 26 yields zero.
REQ-016 ADD: equal signs add magnitudes; differing signs subtract smaller from larger, result sign follows larger magnitude.
REQ-017 NORM: single-cycle leading-zero count and left shift, or 1-bit right shift on carry-out; exponent adjusted accordingly.
REQ-018 Rounding is truncation (round toward zero); no round-to-nearest.
REQ-019 Denormal inputs and results flushed to +0 (32'h00000000); exact cancellation gives +0.
REQ-020 Exponent > 254 after NORM yields signed infinity and sets overflow.
REQ-021 Any NaN operand, or +inf plus -inf, yields 32'h7FC00000 and sets nan_flag; inf plus finite yields that inf.
REQ-022 clear has priority over all else: next cycle acc_out=0, flags=0, state=IDLE, acc_valid=0, including mid-operation (in-flight term discarded).
REQ-023 clear and in_valid in the same cycle: clear wins, term not accepted.
REQ-024 in_valid outside IDLE is ignored (not buffered); upstream holds until in_ready.

Reset
REQ-025 While rst=0 at a rising edge: state=IDLE, acc_out=0, acc_valid=0, overflow=0, nan_flag=0, in_ready=0; in_ready=1 from the first cycle after release.
REQ-026 Reset asserted mid-operation aborts the term with the same values as REQ-025.

Configuration
REQ-027 Macro FP_ACC_TERM_COUNT_EN: when defined, output term_cnt [CNT_W-1:0] counts accepted terms, cleared by reset/clear, saturating at all-ones; when undefined, port and counter absent, all other behaviour identical.

Structure
REQ-028 Shared package fp_pkg holds field widths (EXP_W=8, MAN_W=23), BIAS=127, constants QNAN=32'h7FC00000, POS_INF=32'h7F800000, and the FSM state typedef.
REQ-029 One sub-module fp_lzc (24-bit leading-zero counter, combinational) used by NORM.

Verification
REQ-030 Reset, accept 3F800000 then 40000000 -> acc_valid pulses 4 cycles after each; final acc_out=40400000, overflow=0.
REQ-031 Accept 41200000 then C1A00000 (10 + -20) -> acc_out=C1200000.
REQ-032 Accept 3F800000 then BF800000 -> acc_out=00000000, nan_flag=0.
REQ-033 Accept 7F7FFFFF twice -> acc_out=7F800000, overflow=1 and stays 1 after a further 3F800000 term.
REQ-034 Accept 7F800000 then FF800000 -> acc_out=7FC00000, nan_flag=1; then clear -> acc_out=0, flags 0 next cycle.
REQ-035 Assert clear during ALIGN of a 40000000 term -> no acc_valid pulse, acc_out=0, in_ready=1 the next cycle.
